// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

    // FSM state type and encodings (plain constants so older tools and
    // mixed-language flows see fixed 2-bit values).
    typedef logic [1:0] sa_state_t;

    localparam sa_state_t IDLE = 2'd0;
    localparam sa_state_t RUN  = 2'd1;
    localparam sa_state_t DONE = 2'd2;

    // Width of the bit counter: it counts 0..WIDTH-1 and never wraps.
    function automatic int SA_CNT_W(input int width);
        return $clog2(width);
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell shared by the bit-serial datapath.
// Purely combinational; the caller registers the carry loop.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_s;

    assign half_s = a ^ b;
    assign sum    = half_s ^ cin;
    assign cout   = (a & b) | (cin & half_s);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. On an accepted start the operands and
// carry-in are captured; one bit pair per clock is then fed, LSB first,
// through a single full_adder with a registered carry loop. The result
// registers update only on the completion edge and a one-cycle done
// pulse marks the cycle in which they hold the new result.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W    = SA_CNT_W(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // FSM and counter
    sa_state_t        state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // Operand shift registers and carry loop
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic             carry_q,  carry_d;

    // Sum accumulator: holds the WIDTH-1 most recent sum bits, MSB-aligned.
    // The final bit of an operation never needs to be stored here because
    // it is written straight into the result register together with these.
    logic [WIDTH-2:0] acc_sr_q, acc_sr_d;
    logic [WIDTH-1:0] acc_next_s;

    // Result and status registers
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Full adder interface
    logic             fa_sum_s;
    logic             fa_cout_s;

    full_adder u_full_adder (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Accumulator contents after this cycle's sum bit is shifted in at the MSB.
    assign acc_next_s = {fa_sum_s, acc_sr_q};

    // Next-state logic: FSM, operand capture, serial shift and result capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        carry_d  = carry_q;
        acc_sr_d = acc_sr_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    acc_sr_d = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end

            RUN: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                acc_sr_d = acc_next_s[WIDTH-1:1];
                carry_d  = fa_cout_s;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: the counter holds rather than wrapping, and the
                    // result registers take the completed sum and final carry.
                    cnt_d   = cnt_q;
                    sum_d   = acc_next_s;
                    cout_d  = fa_cout_s;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = RUN;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are decodes of the next state, registered so that they
    // are plain state decodes in the cycle they are observed.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State registers with synchronous active-high reset; reset clears the
    // datapath and the result, aborting any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            carry_q  <= 1'b0;
            acc_sr_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            carry_q  <= carry_d;
            acc_sr_q <= acc_sr_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around one instance of the team's single-bit `full_adder`. It captures two operands and a carry-in on a start request. It then feeds the full adder one bit pair per clock, LSB first, with a registered carry loop. It presents the registered sum and carry-out with a one-cycle `done` pulse, trading WIDTH cycles of latency for a single adder cell.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range ≥ 2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  WIDTH: operand A; captured on the accepted start edge.
- `b`  in  WIDTH: operand B; captured on the accepted start edge.
- `cin`  in  1: carry-in; captured on the accepted start edge.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse; `sum`/`cout` are valid in that cycle.
- `sum`  out  WIDTH: result register, equal to (a + b + cin) mod 2^WIDTH.
- `cout`  out  1: result carry-out, the bit WIDTH of a + b + cin.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: load `a_sr`←a, `b_sr`←b, `carry`←cin, `cnt`←0; next state RUN. With start=0, remain in IDLE.
- RUN, each cycle:
  - The full adder sees `a_sr[0]`, `b_sr[0]`, `carry`.
  - `a_sr`/`b_sr` shift right by 1.
  - The full-adder sum bit enters `acc_sr` at the MSB (shift right).
  - `carry`←full-adder cout; `cnt`←cnt+1.
- RUN, cycle with cnt==WIDTH-1:
  - The last bit is processed as above.
  - `sum`←final accumulator value, including this bit; `cout`←final full-adder cout.
  - Next state DONE.
- DONE: `done`=1 for exactly this cycle; next state IDLE unconditionally.
- `start` is ignored in RUN and DONE. No queuing: a request is lost unless it is presented in IDLE.
- `sum`/`cout` change only on a completion edge. They hold their value through IDLE and through the next operation until that operation completes.
- `cnt` width is $clog2(WIDTH). The counter never wraps; the state exits RUN at WIDTH-1.
- Input values of `a`/`b`/`cin` outside the accepting edge have no effect.

## Timing
- Reset (rst=1 at an edge):
  - state←IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - `a_sr`, `b_sr`, `acc_sr`, `carry`, `cnt`←0.
  - rst dominates start.
- Reset during RUN or DONE aborts the operation: no `done` pulse, and `sum`/`cout` are cleared to 0.
- Latency, with start accepted at edge E0:
  - `busy` rises after E0.
  - RUN covers edges E1..E_WIDTH.
  - `done`=1 and `sum`/`cout` are valid in the cycle after edge E_WIDTH.
  - `busy` falls after edge E_WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles when `start` is held high continuously. IDLE at E_WIDTH+1 accepts at E_WIDTH+2.
- `busy` and `done` are registered state decodes: `busy`=(state!=IDLE), `done`=(state==DONE). Neither has a combinational path from inputs.

## Structure
- Shared package `serial_adder_pkg`:
  - state typedef/localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - `SA_CNT_W(WIDTH)` helper constant = $clog2(WIDTH).
- Sub-module: one instance of the existing `full_adder` (ports `a`, `b`, `cin`, `sum`, `cout`). Its inputs are driven from the shift-register LSBs and the carry register.
- Remaining logic: FSM, counter, three shift registers, result registers. No further sub-modules.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 → `done` pulse exactly 8 edges after the start edge; sum=0x96, cout=0; `busy` high for 9 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Hold start=1 continuously with new operands each cycle → accepts only at IDLE edges, one result per 10 cycles. Each result matches the operands present at its accepting edge.
- Pulse start while busy, with different operands, at cycles 3 and 9 after acceptance → ignored; the result matches the original operands.
- rst=1 at RUN cycle 4 → next cycle state IDLE, busy=0, sum=0, cout=0, no `done` pulse. A new start afterwards completes correctly.
- Randomized a/b/cin, 1000 operations at WIDTH=8 and WIDTH=2 → every `done` cycle satisfies {cout,sum} == a+b+cin.
